// File: rtl/neuron_io_hs_frontend.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | neuron_io_hs_frontend: pad-side 4-phase handshake frontend with input FIFO |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module neuron_io_hs_frontend #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              ena,
    input  logic [DATA_W-1:0]                 in_data_pad,
    input  logic                              in_req_pad,
    output logic                              in_ack_pad,
    output logic [DATA_W-1:0]                 out_data_pad,
    output logic                              out_req_pad,
    input  logic                              out_ack_pad,
    output logic [DATA_W-1:0]                 rx_data,
    output logic                              rx_valid,
    input  logic                              rx_ready,
    input  logic [DATA_W-1:0]                 tx_data,
    input  logic                              tx_valid,
    output logic                              tx_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              proto_err,
    input  logic                              err_clr
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH+1);
    localparam logic [LVL_W-1:0] DEPTH_LVL = LVL_W'(FIFO_DEPTH);

    localparam logic [0:0] IN_IDLE  = 1'b0;
    localparam logic [0:0] IN_ACK   = 1'b1;

    localparam logic [1:0] OUT_IDLE = 2'b00;
    localparam logic [1:0] OUT_REQ  = 2'b01;
    localparam logic [1:0] OUT_REL  = 2'b10;

    logic [SYNC_STAGES-1:0] req_sync_q;
    logic [SYNC_STAGES-1:0] ack_sync_q;
    logic [DATA_W-1:0]      data_sync_q [SYNC_STAGES];
    logic                   ack_prev_q;
    logic                   in_req_s;
    logic                   out_ack_s;
    logic [DATA_W-1:0]      in_data_s;

    logic [0:0]             in_state_q, in_state_d;
    logic                   in_ack_q, in_ack_d;
    logic                   push;

    logic [1:0]             out_state_q, out_state_d;
    logic                   out_req_q, out_req_d;
    logic [DATA_W-1:0]      out_data_q, out_data_d;
    logic                   launch;
    logic                   run_q;

    logic [DATA_W-1:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   pop;
    logic                   fifo_full;

    logic                   proto_err_q, proto_err_d;
    logic                   violation;

    // Pad synchronisers; data rides alongside req and is stable while req is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_sync_q <= '0;
            ack_sync_q <= '0;
            ack_prev_q <= 1'b0;
            for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
        end else begin
            req_sync_q     <= {req_sync_q[SYNC_STAGES-2:0], in_req_pad};
            ack_sync_q     <= {ack_sync_q[SYNC_STAGES-2:0], out_ack_pad};
            ack_prev_q     <= ack_sync_q[SYNC_STAGES-1];
            data_sync_q[0] <= in_data_pad;
            for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
        end
    end

    assign in_req_s  = req_sync_q[SYNC_STAGES-1];
    assign out_ack_s = ack_sync_q[SYNC_STAGES-1];
    assign in_data_s = data_sync_q[SYNC_STAGES-1];

    // Input FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_state_q <= IN_IDLE;
            in_ack_q   <= 1'b0;
        end else begin
            in_state_q <= in_state_d;
            in_ack_q   <= in_ack_d;
        end
    end

    always_comb begin
        in_state_d = in_state_q;
        case (in_state_q)
            IN_IDLE: if (in_req_s && ena && !fifo_full) in_state_d = IN_ACK;
            IN_ACK:  if (!in_req_s)                     in_state_d = IN_IDLE;
            default:                                    in_state_d = IN_IDLE;
        endcase
    end

    always_comb begin
        push     = (in_state_q == IN_IDLE) && (in_state_d == IN_ACK);
        in_ack_d = (in_state_d == IN_ACK);
    end

    assign in_ack_pad = in_ack_q;

    // Input FIFO; fullness comes from the registered level so a same-cycle pop never frees a slot early
    assign fifo_full = (level_q == DEPTH_LVL);
    assign rx_valid  = (level_q != '0);
    assign pop       = rx_valid && rx_ready;
    assign rx_data   = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_data_s;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q <= level_d;
        end
    end

    assign fifo_level = level_q;

    // Output FSM; run_q keeps tx_ready low until the first clock after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_state_q <= OUT_IDLE;
            out_req_q   <= 1'b0;
            out_data_q  <= '0;
            run_q       <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            out_req_q   <= out_req_d;
            out_data_q  <= out_data_d;
            run_q       <= 1'b1;
        end
    end

    always_comb begin
        out_state_d = out_state_q;
        case (out_state_q)
            OUT_IDLE: if (launch)     out_state_d = OUT_REQ;
            OUT_REQ:  if (out_ack_s)  out_state_d = OUT_REL;
            OUT_REL:  if (!out_ack_s) out_state_d = OUT_IDLE;
            default:                  out_state_d = OUT_IDLE;
        endcase
    end

    always_comb begin
        tx_ready   = (out_state_q == OUT_IDLE) && ena && run_q;
        launch     = tx_valid && tx_ready;
        out_req_d  = (out_state_d == OUT_REQ);
        out_data_d = launch ? tx_data : out_data_q;
    end

    assign out_req_pad  = out_req_q;
    assign out_data_pad = out_data_q;

    // Sticky protocol error: an ack edge with no request outstanding; set beats clear
    assign violation   = (out_state_q == OUT_IDLE) && out_ack_s && !ack_prev_q;
    assign proto_err_d = (proto_err_q && !err_clr) || violation;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) proto_err_q <= 1'b0;
        else        proto_err_q <= proto_err_d;
    end

    assign proto_err = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_neuron_io_hs_frontend.sv
`default_nettype none
// Directed bench for neuron_io_hs_frontend (DATA_W=8, SYNC_STAGES=2, FIFO_DEPTH=4).
module tb_neuron_io_hs_frontend;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] in_data_pad;
    logic       in_req_pad;
    logic       in_ack_pad;
    logic [7:0] out_data_pad;
    logic       out_req_pad;
    logic       out_ack_pad;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [2:0] fifo_level;
    logic       proto_err;
    logic       err_clr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    neuron_io_hs_frontend #(
        .DATA_W     (8),
        .SYNC_STAGES(2),
        .FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .in_data_pad (in_data_pad),
        .in_req_pad  (in_req_pad),
        .in_ack_pad  (in_ack_pad),
        .out_data_pad(out_data_pad),
        .out_req_pad (out_req_pad),
        .out_ack_pad (out_ack_pad),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .fifo_level  (fifo_level),
        .proto_err   (proto_err),
        .err_clr     (err_clr)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_in_ack(input logic lvl, output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (in_ack_pad === lvl) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
    endtask

    task automatic send_word(input logic [7:0] d, input string tag);
        logic ok;
        in_data_pad = d;
        in_req_pad  = 1'b1;
        wait_in_ack(1'b1, ok);
        check({tag, "_ack_hi"}, {31'd0, ok}, 32'd1);
        in_req_pad = 1'b0;
        wait_in_ack(1'b0, ok);
        check({tag, "_ack_lo"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic ok;
        rst_n = 1'b0; ena = 1'b0; in_data_pad = '0; in_req_pad = 1'b0;
        out_ack_pad = 1'b0; rx_ready = 1'b0; tx_data = '0; tx_valid = 1'b0; err_clr = 1'b0;
        tick(3);

        // Reset values
        check("rst_in_ack",   in_ack_pad,   0);
        check("rst_out_req",  out_req_pad,  0);
        check("rst_out_data", out_data_pad, 0);
        check("rst_rx_valid", rx_valid,     0);
        check("rst_rx_data",  rx_data,      0);
        check("rst_level",    fifo_level,   0);
        check("rst_proto",    proto_err,    0);
        check("rst_tx_ready", tx_ready,     0);

        rst_n = 1'b1;
        tick(1);
        ena = 1'b1;

        // Single word: ack rises exactly 3 cycles after req
        in_data_pad = 8'hA5;
        in_req_pad  = 1'b1;
        tick(2);
        check("lat_ack_early", in_ack_pad, 0);
        tick(1);
        check("lat_ack",      in_ack_pad, 1);
        check("one_rx_valid", rx_valid,   1);
        check("one_rx_data",  rx_data,    8'hA5);
        check("one_level",    fifo_level, 1);
        in_req_pad = 1'b0;
        tick(2);
        check("rtz_ack_early", in_ack_pad, 1);
        tick(1);
        check("rtz_ack", in_ack_pad, 0);
        pop_one();
        check("pop_level", fifo_level, 0);
        check("pop_valid", rx_valid,   0);

        // Push and pop in the same cycle leaves the level unchanged
        send_word(8'h11, "pp_first");
        in_data_pad = 8'h22;
        in_req_pad  = 1'b1;
        tick(2);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        check("pp_ack",   in_ack_pad, 1);
        check("pp_level", fifo_level, 1);
        check("pp_data",  rx_data,    8'h22);
        in_req_pad = 1'b0;
        wait_in_ack(1'b0, ok);
        check("pp_ack_lo", {31'd0, ok}, 1);
        pop_one();
        check("pp_empty", fifo_level, 0);

        // Fill past depth: fifth word is held off until a slot frees up
        for (int i = 1; i <= 4; i++) send_word(8'(i), "fill");
        check("full_level", fifo_level, 4);
        in_data_pad = 8'h05;
        in_req_pad  = 1'b1;
        tick(10);
        check("full_no_ack", in_ack_pad, 0);
        check("full_level2", fifo_level, 4);
        pop_one();
        check("full_pop_level", fifo_level, 3);
        check("full_no_ack2",   in_ack_pad, 0);
        tick(1);
        check("full_ack5",   in_ack_pad, 1);
        check("full_level5", fifo_level, 4);
        in_req_pad = 1'b0;
        wait_in_ack(1'b0, ok);
        check("full_ack5_lo", {31'd0, ok}, 1);
        for (int i = 2; i <= 5; i++) begin
            check("drain_valid", rx_valid, 1);
            check("drain_data",  rx_data,  i);
            pop_one();
        end
        check("drain_empty", fifo_level, 0);

        // Output word
        check("tx_ready_idle", tx_ready, 1);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        check("out_req",      out_req_pad,  1);
        check("out_data",     out_data_pad, 8'h3C);
        check("tx_ready_busy", tx_ready,    0);
        out_ack_pad = 1'b1;
        tick(2);
        check("out_req_early", out_req_pad, 1);
        tick(1);
        check("out_req_drop", out_req_pad, 0);
        tx_data = 8'hFF;
        check("out_data_hold", out_data_pad, 8'h3C);
        out_ack_pad = 1'b0;
        tick(2);
        check("tx_ready_early", tx_ready, 0);
        tick(1);
        check("tx_ready_back", tx_ready, 1);
        check("no_proto_err",  proto_err, 0);

        // ena low mid-handshake: current RTZ completes, new starts blocked
        in_data_pad = 8'h77;
        in_req_pad  = 1'b1;
        wait_in_ack(1'b1, ok);
        check("ena_ack_hi", {31'd0, ok}, 1);
        ena        = 1'b0;
        in_req_pad = 1'b0;
        tick(3);
        check("ena_rtz", in_ack_pad, 0);
        check("ena_tx_ready", tx_ready, 0);
        in_data_pad = 8'h88;
        in_req_pad  = 1'b1;
        tick(8);
        check("ena_blocked", in_ack_pad, 0);
        check("ena_level1",  fifo_level, 1);
        ena = 1'b1;
        tick(1);
        check("ena_resume", in_ack_pad, 1);
        check("ena_level2", fifo_level, 2);
        check("ena_head",   rx_data,    8'h77);
        in_req_pad = 1'b0;
        wait_in_ack(1'b0, ok);
        check("ena_ack_lo", {31'd0, ok}, 1);

        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        tick(1);
        tx_valid    = 1'b0;
        ena         = 1'b0;
        out_ack_pad = 1'b1;
        tick(3);
        check("ena_out_rtz", out_req_pad, 0);
        out_ack_pad = 1'b0;
        tick(3);
        check("ena_out_blocked", tx_ready, 0);
        ena = 1'b1;
        #1;
        check("ena_out_ready", tx_ready, 1);

        // Protocol error: ack while idle, sticky, clear, set-beats-clear
        out_ack_pad = 1'b1;
        tick(2);
        check("perr_early", proto_err, 0);
        tick(1);
        check("perr_set", proto_err, 1);
        out_ack_pad = 1'b0;
        tick(4);
        check("perr_sticky", proto_err, 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("perr_clr", proto_err, 0);
        out_ack_pad = 1'b1;
        tick(2);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("perr_set_wins", proto_err, 1);
        out_ack_pad = 1'b0;
        tick(3);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("perr_clr2", proto_err, 0);

        // Reset mid-transfer with two words queued
        in_data_pad = 8'h99;
        in_req_pad  = 1'b1;
        tx_data     = 8'hC3;
        tx_valid    = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tick(2);
        check("pre_rst_ack",   in_ack_pad,  1);
        check("pre_rst_req",   out_req_pad, 1);
        check("pre_rst_level", fifo_level,  3);
        rst_n = 1'b0;
        #2;
        check("arst_in_ack",   in_ack_pad,   0);
        check("arst_out_req",  out_req_pad,  0);
        check("arst_out_data", out_data_pad, 0);
        check("arst_rx_valid", rx_valid,     0);
        check("arst_rx_data",  rx_data,      0);
        check("arst_level",    fifo_level,   0);
        check("arst_tx_ready", tx_ready,     0);
        in_req_pad = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        check("post_rst_level", fifo_level, 0);
        check("post_rst_ready", tx_ready,   1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
